// File: rtl/decoder4to16_seq.sv
// Registered 4-to-16 one-hot decoder with a single output slot and valid/ready handshake.
// Define DECODER4TO16_SEQ_SCAN_EN to compile in the self-test scan walk (IDLE/SCAN FSM).
module decoder4to16_seq #(
    parameter int unsigned SCAN_DWELL = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic        scan_start,
    output logic [15:0] o,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        busy
);

    logic       slot_free;
    logic       in_load;
    logic       scan_load;
    logic [3:0] load_code;

    assign slot_free = !o_valid || o_ready;
    assign in_load   = i_valid && i_ready;

`ifdef DECODER4TO16_SEQ_SCAN_EN
    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_SCAN      = 1'b1;
    localparam logic [7:0] DWELL_RELOAD = 8'(SCAN_DWELL - 1);

    logic [0:0] state;
    logic [3:0] code;
    logic [7:0] dwell;

    assign i_ready   = !rst && (state == ST_IDLE) && !scan_start && slot_free;
    assign scan_load = (state == ST_SCAN) && (dwell == '0) && slot_free;
    assign busy      = (state == ST_SCAN);
    assign load_code = scan_load ? code : i;

    // A blocked slot leaves dwell parked at zero, so the pending code is retried, not skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            code  <= '0;
            dwell <= '0;
        end else if (state == ST_IDLE) begin
            if (scan_start) begin
                state <= ST_SCAN;
                code  <= '0;
                dwell <= '0;
            end
        end else if (scan_load) begin
            dwell <= DWELL_RELOAD;
            if (code == 4'd15) begin
                state <= ST_IDLE;
            end else begin
                code <= code + 4'd1;
            end
        end else if (dwell != '0) begin
            dwell <= dwell - 8'd1;
        end
    end
`else
    logic unused_scan;

    assign i_ready     = !rst && slot_free;
    assign scan_load   = 1'b0;
    assign busy        = 1'b0;
    assign load_code   = i;
    assign unused_scan = ^{scan_start, 8'(SCAN_DWELL)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= '0;
            o_valid <= 1'b0;
        end else if (in_load || scan_load) begin
            o       <= 16'd1 << load_code;
            o_valid <= 1'b1;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder4to16_seq.sv
// Randomized self-checking bench for decoder4to16_seq against a cycle-level behavioural model.
// Follows DECODER4TO16_SEQ_SCAN_EN so the same bench covers both builds.
module tb_decoder4to16_seq;

    localparam int unsigned DWELL = 10;
`ifdef DECODER4TO16_SEQ_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i = '0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic        scan_start = 1'b0;
    logic [15:0] o;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: the output slot plus the scan walk as "next code" and "cycles to wait".
    logic [15:0] m_o = '0;
    bit          m_v = 1'b0;
    bit          m_scan = 1'b0;
    int          m_code = 0;
    int          m_wait = 0;

    decoder4to16_seq #(.SCAN_DWELL(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .i          (i),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .scan_start (scan_start),
        .o          (o),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return !rst && !m_scan && !(SCAN_EN && scan_start) && (!m_v || o_ready);
    endfunction

    task automatic model_step();
        bit free, accept, sload, was_scan;
        if (rst) begin
            m_o = '0; m_v = 1'b0; m_scan = 1'b0; m_code = 0; m_wait = 0;
            return;
        end
        was_scan = m_scan;
        free     = !m_v || o_ready;
        accept   = i_valid && !was_scan && !(SCAN_EN && scan_start) && free;
        sload    = was_scan && (m_wait == 0) && free;
        if (sload) begin
            m_o = 16'(32'd1 << m_code);
            m_v = 1'b1;
            if (m_code == 15) m_scan = 1'b0;
            else m_code++;
            m_wait = DWELL - 1;
        end else if (was_scan && m_wait > 0) begin
            m_wait--;
        end
        if (accept) begin
            m_o = 16'(32'd1 << i);
            m_v = 1'b1;
        end else if (!sload && o_ready) begin
            m_v = 1'b0;
        end
        if (!was_scan && SCAN_EN && scan_start) begin
            m_scan = 1'b1; m_code = 0; m_wait = 0;
        end
    endtask

    // Drive one cycle of inputs, check i_ready before the edge and all outputs after it.
    task automatic step(input bit r, input logic [3:0] c, input bit v, input bit ss, input bit ordy);
        rst = r; i = c; i_valid = v; scan_start = ss; o_ready = ordy;
        #1;
        check("i_ready", 32'(i_ready), 32'(exp_ready()));
        @(posedge clk);
        model_step();
        #1;
        check("o", 32'(o), 32'(m_o));
        check("o_valid", 32'(o_valid), 32'(m_v));
        check("busy", 32'(busy), 32'(m_scan));
        check("onehot", 32'($countones(o) <= 1), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int beats, last_t, t;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 4'd7, 1, 1, 1);
        check("rst_o", 32'(o), 32'd0);

        // Back-to-back decode of every code at full throughput
        for (int k = 0; k < 16; k++) begin
            step(0, 4'(k), 1, 0, 1);
            check("stream_o", 32'(o), 32'h1 << k);
        end
        step(0, 0, 0, 0, 1);
        check("stream_drain", 32'(o_valid), 32'd0);

        // Backpressure hold
        step(0, 4'd9, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 4'($urandom_range(15)), 1, 0, 0);
            check("hold_o", 32'(o), 32'h0200);
        end
        step(0, 0, 0, 0, 1);
        check("hold_release", 32'(o_valid), 32'd0);
        check("hold_keep_o", 32'(o), 32'h0200);

        // scan_start beats a simultaneous input; then count beats and spacing
        step(0, 4'd3, 1, 1, 1);
        beats = 0; last_t = -1; t = 0;
        for (int k = 0; k < 200; k++) begin
            step(0, 0, 0, 0, 1);
            t++;
            if (o_valid) begin
                if (beats == 0) check("first_beat", 32'(o), SCAN_EN ? 32'h0001 : 32'h0008);
                else check("beat_gap", 32'(t - last_t), 32'(DWELL));
                beats++;
                last_t = t;
            end
        end
        check("beat_count", 32'(beats), SCAN_EN ? 32'd16 : 32'd0);
        check("scan_done_busy", 32'(busy), 32'd0);

`ifdef DECODER4TO16_SEQ_SCAN_EN
        // Reset mid-scan right after the 0x0010 beat
        step(0, 0, 0, 1, 1);
        for (int k = 0; k < 100 && !(o_valid && o == 16'h0010); k++) step(0, 0, 0, 0, 1);
        check("wait_0010", 32'(o_valid && o == 16'h0010), 32'd1);
        step(1, 0, 0, 0, 1);
        check("abort_o", 32'(o), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
`else
        step(0, 0, 0, 1, 1);
        check("noscan_busy", 32'(busy), 32'd0);
`endif
        step(0, 4'd5, 1, 0, 1);
        check("after_abort", 32'(o), 32'h0020);

        // Randomized traffic with occasional scans, stalls and resets
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(199) == 0), 4'($urandom_range(15)), $urandom_range(1) == 1,
                 ($urandom_range(39) == 0), ($urandom_range(9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
